// File: rtl/dataflow_deadlock_pkg.sv
// Shared types and boolean-matrix helpers for the dataflow deadlock monitor.
// Matrices are flattened row-major with stride n: bit i*n+j means process i waits on j.
package dataflow_deadlock_pkg;
   localparam int DL_MAX_PROC = 16;
   localparam int DL_IDX_W    = $clog2(DL_MAX_PROC);
   localparam int DL_MAT_W    = DL_MAX_PROC * DL_MAX_PROC;

   typedef enum logic [2:0] {IDLE, STABLE, CLOSE, CHECK, HOLD} dl_state_t;
   typedef logic [DL_MAT_W-1:0]    dl_mat_t;
   typedef logic [DL_MAX_PROC-1:0] dl_vec_t;

   // Returns r | r*r; only the low n*n bits are meaningful.
   function automatic dl_mat_t bool_mat_square(input dl_mat_t r, input int n);
      dl_mat_t sq;
      sq = r;
      for (int i = 0; i < DL_MAX_PROC; i++)
         for (int j = 0; j < DL_MAX_PROC; j++)
            for (int k = 0; k < DL_MAX_PROC; k++)
               if (i < n && j < n && k < n)
                  sq[i*n+j] = sq[i*n+j] | (r[i*n+k] & r[k*n+j]);
      return sq;
   endfunction

   function automatic logic [DL_IDX_W-1:0] lowest_set(input dl_vec_t v);
      logic [DL_IDX_W-1:0] idx;
      idx = '0;
      for (int i = DL_MAX_PROC - 1; i >= 0; i--)
         if (v[i]) idx = DL_IDX_W'(i);
      return idx;
   endfunction
endpackage

// File: rtl/dataflow_deadlock_monitor_closure_step.sv
// One squaring step of the boolean transitive closure: r_out = r_in | r_in*r_in.
module dl_closure_step import dataflow_deadlock_pkg::*; #(
   parameter int N = 4
) (
   input  logic [N*N-1:0] r_in,
   output logic [N*N-1:0] r_out
);
   localparam int NN = N * N;

   always_comb r_out = NN'(bool_mat_square(DL_MAT_W'(r_in), N));
endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// Deadlock monitor for dataflow regions: waits for a stable wait-for matrix,
// computes its transitive closure one squaring per cycle and reports the first cycle.
module dataflow_deadlock_monitor import dataflow_deadlock_pkg::*; #(
   parameter  int N_PROC        = 4,
   parameter  int STABLE_CYCLES = 16,
   parameter  int CNT_W         = 16,
   localparam int ITER          = (N_PROC > 2) ? $clog2(N_PROC) : 1,
   localparam int OW            = (N_PROC > 2) ? $clog2(N_PROC) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [N_PROC*N_PROC-1:0] wait_mat,
   output logic                     busy,
   output logic                     deadlock,
   output logic                     dl_valid,
   output logic [OW-1:0]            dl_origin,
   output logic [N_PROC-1:0]        dl_members,
   output logic [CNT_W-1:0]         dl_count
);
   localparam int NN = N_PROC * N_PROC;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int SW = $clog2(ITER + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(ITER - 1);

   dl_state_t         state_q, state_d;
   logic [NN-1:0]     w_q, w_d, r_q, r_d, r_sq;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SW-1:0]     step_q, step_d;
   logic              busy_q, busy_d, deadlock_q, deadlock_d, dl_valid_q, dl_valid_d;
   logic [OW-1:0]     origin_q, origin_d, origin_c;
   logic [N_PROC-1:0] members_q, members_d, members_c, diag;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              changed;

   dl_closure_step #(.N(N_PROC)) u_step (.r_in(r_q), .r_out(r_sq));

   // Origin is the lowest process that reaches itself; members are mutually reachable with it.
   always_comb begin
      diag = '0;
      for (int i = 0; i < N_PROC; i++) diag[i] = r_q[i*N_PROC+i];
      origin_c  = OW'(lowest_set(DL_MAX_PROC'(diag)));
      members_c = '0;
      for (int o = 0; o < N_PROC; o++)
         if (origin_c == OW'(o)) begin
            for (int j = 0; j < N_PROC; j++)
               members_c[j] = r_q[o*N_PROC+j] & r_q[j*N_PROC+o];
            members_c[o] = 1'b1;
         end
   end

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      r_d        = r_q;
      cnt_d      = cnt_q;
      step_d     = step_q;
      deadlock_d = deadlock_q;
      dl_valid_d = 1'b0;
      origin_d   = origin_q;
      members_d  = members_q;
      count_d    = count_q;
      changed    = (wait_mat != w_q);
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable) state_d = STABLE;
         end
         STABLE: begin
            if (changed) begin
               w_d   = wait_mat;
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST && w_q != '0) begin
               state_d = CLOSE;
               r_d     = w_q;
               step_d  = '0;
            end else if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CLOSE: begin
            if (changed) begin
               state_d = STABLE;
               w_d     = wait_mat;
               cnt_d   = '0;
            end else begin
               r_d    = r_sq;
               step_d = step_q + 1'b1;
               if (step_q == STEP_LAST) state_d = CHECK;
            end
         end
         CHECK: begin
            if (diag != '0) begin
               state_d    = HOLD;
               deadlock_d = 1'b1;
               dl_valid_d = 1'b1;
               origin_d   = origin_c;
               members_d  = members_c;
               count_d    = (count_q == '1) ? count_q : count_q + 1'b1;
            end else begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (changed) begin
               state_d = STABLE;
               w_d     = wait_mat;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
      // clear wins over a report computed in the same cycle
      if (clear) begin
         state_d    = enable ? STABLE : IDLE;
         cnt_d      = '0;
         deadlock_d = 1'b0;
         dl_valid_d = 1'b0;
         origin_d   = '0;
         members_d  = '0;
         count_d    = '0;
      end
      busy_d = (state_d == CLOSE) || (state_d == CHECK);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         w_q        <= '0;
         r_q        <= '0;
         cnt_q      <= '0;
         step_q     <= '0;
         busy_q     <= 1'b0;
         deadlock_q <= 1'b0;
         dl_valid_q <= 1'b0;
         origin_q   <= '0;
         members_q  <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         r_q        <= r_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         busy_q     <= busy_d;
         deadlock_q <= deadlock_d;
         dl_valid_q <= dl_valid_d;
         origin_q   <= origin_d;
         members_q  <= members_d;
         count_q    <= count_d;
      end
   end

   assign busy       = busy_q;
   assign deadlock   = deadlock_q;
   assign dl_valid   = dl_valid_q;
   assign dl_origin  = origin_q;
   assign dl_members = members_q;
   assign dl_count   = count_q;
endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Directed bench for dataflow_deadlock_monitor: default 4-process instance plus
// an 8-process instance with a 2-bit counter for saturation and async reset.
module tb_dataflow_deadlock_monitor;
   logic        clock = 1'b0, reset = 1'b0;
   logic        enable = 1'b0, clear = 1'b0;
   logic [15:0] wait_mat = '0;
   logic        busy, deadlock, dl_valid;
   logic [1:0]  dl_origin;
   logic [3:0]  dl_members;
   logic [15:0] dl_count;

   logic        enable8 = 1'b0, clear8 = 1'b0;
   logic [63:0] wait8 = '0;
   logic        busy8, deadlock8, dl_valid8;
   logic [2:0]  origin8;
   logic [7:0]  members8;
   logic [1:0]  count8;

   int checks = 0, failures = 0;

   always #5 clock = ~clock;

   dataflow_deadlock_monitor dut (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear), .wait_mat(wait_mat),
      .busy(busy), .deadlock(deadlock), .dl_valid(dl_valid), .dl_origin(dl_origin),
      .dl_members(dl_members), .dl_count(dl_count));

   dataflow_deadlock_monitor #(.N_PROC(8), .STABLE_CYCLES(16), .CNT_W(2)) dut8 (
      .clock(clock), .reset(reset), .enable(enable8), .clear(clear8), .wait_mat(wait8),
      .busy(busy8), .deadlock(deadlock8), .dl_valid(dl_valid8), .dl_origin(origin8),
      .dl_members(members8), .dl_count(count8));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Advance n cycles, recording dl_valid pulses and busy cycles of one instance.
   task automatic run(input int sel, input int n, output int pulses, output int first_v,
                      output int nbusy, output int first_b);
      logic v, b;
      pulses = 0; first_v = -1; nbusy = 0; first_b = -1;
      for (int c = 1; c <= n; c++) begin
         step();
         v = (sel == 1) ? dl_valid : dl_valid8;
         b = (sel == 1) ? busy : busy8;
         if (v) begin pulses++; if (first_v < 0) first_v = c; end
         if (b) begin nbusy++; if (first_b < 0) first_b = c; end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({busy, deadlock, dl_valid, dl_origin, dl_members, dl_count} !== 25'd0) begin
         failures++;
         $display("FAIL reset_dut4 got=%h want=0", {busy, deadlock, dl_valid, dl_origin, dl_members, dl_count});
      end
      checks++;
      if ({busy8, deadlock8, dl_valid8, origin8, members8, count8} !== 16'd0) begin
         failures++;
         $display("FAIL reset_dut8 got=%h want=0", {busy8, deadlock8, dl_valid8, origin8, members8, count8});
      end
      reset = 1'b1; enable = 1'b1; enable8 = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({busy, dl_valid, deadlock} !== 3'b000) begin
         failures++; $display("FAIL idle_after_reset got=%b want=000", {busy, dl_valid, deadlock});
      end
   endtask

   task automatic test_two_cycle();
      int p, fv, nb, fb;
      wait_mat = 16'h0012;
      run(1, 25, p, fv, nb, fb);
      checks++; if (fv !== 20) begin failures++; $display("FAIL two_cycle_latency got=%0d want=20", fv); end
      checks++; if (p !== 1) begin failures++; $display("FAIL two_cycle_pulses got=%0d want=1", p); end
      checks++; if (fb !== 17 || nb !== 3) begin failures++; $display("FAIL two_cycle_busy got=%0d/%0d want=17/3", fb, nb); end
      checks++; if (dl_origin !== 2'd0) begin failures++; $display("FAIL two_cycle_origin got=%0d want=0", dl_origin); end
      checks++; if (dl_members !== 4'b0011) begin failures++; $display("FAIL two_cycle_members got=%b want=0011", dl_members); end
      checks++; if (deadlock !== 1'b1 || dl_count !== 16'd1) begin
         failures++; $display("FAIL two_cycle_flag got=%b/%0d want=1/1", deadlock, dl_count);
      end
   endtask

   task automatic test_three_cycle();
      int p, fv, nb, fb;
      wait_mat = 16'h2842;
      run(1, 25, p, fv, nb, fb);
      checks++; if (fv !== 20 || p !== 1) begin failures++; $display("FAIL three_cycle_pulse got=%0d/%0d want=20/1", fv, p); end
      checks++; if (dl_origin !== 2'd1) begin failures++; $display("FAIL three_cycle_origin got=%0d want=1", dl_origin); end
      checks++; if (dl_members !== 4'b1110) begin failures++; $display("FAIL three_cycle_members got=%b want=1110", dl_members); end
      checks++; if (dl_count !== 16'd2) begin failures++; $display("FAIL three_cycle_count got=%0d want=2", dl_count); end
   endtask

   task automatic test_chain();
      int p, fv, nb, fb;
      clear = 1'b1; wait_mat = 16'h0842;
      step();
      clear = 1'b0;
      checks++;
      if ({deadlock, dl_valid, dl_origin, dl_members, dl_count} !== 24'd0) begin
         failures++; $display("FAIL clear_outputs got=%h want=0", {deadlock, dl_valid, dl_origin, dl_members, dl_count});
      end
      run(1, 99, p, fv, nb, fb);
      checks++; if (p !== 0 || deadlock !== 1'b0) begin failures++; $display("FAIL chain_report got=%0d/%b want=0/0", p, deadlock); end
      checks++; if (fb !== 16 || nb !== 15) begin failures++; $display("FAIL chain_busy got=%0d/%0d want=16/15", fb, nb); end
   endtask

   task automatic test_toggle();
      int p, fv, nb, fb, tp, tb;
      tp = 0; tb = 0;
      for (int r = 0; r < 6; r++) begin
         wait_mat = (r % 2 == 1) ? 16'h0013 : 16'h0012;
         run(1, 10, p, fv, nb, fb);
         tp += p; tb += nb;
      end
      checks++; if (tb !== 0 || tp !== 0) begin failures++; $display("FAIL toggle_never_close got=%0d/%0d want=0/0", tb, tp); end
   endtask

   task automatic test_abort();
      int p, fv, nb, fb;
      wait_mat = 16'h0012;
      run(1, 17, p, fv, nb, fb);
      checks++; if (busy !== 1'b1 || fb !== 17) begin failures++; $display("FAIL abort_enter_close got=%b/%0d want=1/17", busy, fb); end
      wait_mat = 16'h2842;
      run(1, 25, p, fv, nb, fb);
      checks++; if (fb !== 17 || nb !== 3) begin failures++; $display("FAIL abort_restart got=%0d/%0d want=17/3", fb, nb); end
      checks++; if (p !== 1 || fv !== 20) begin failures++; $display("FAIL abort_pulse got=%0d/%0d want=1/20", p, fv); end
      checks++; if (dl_origin !== 2'd1 || dl_count !== 16'd1) begin
         failures++; $display("FAIL abort_report got=%0d/%0d want=1/1", dl_origin, dl_count);
      end
   endtask

   task automatic test_hold_clear();
      int p, fv, nb, fb;
      run(1, 50, p, fv, nb, fb);
      checks++; if (p !== 0 || deadlock !== 1'b1) begin failures++; $display("FAIL hold_single got=%0d/%b want=0/1", p, deadlock); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if ({busy, deadlock, dl_valid, dl_origin, dl_members, dl_count} !== 25'd0) begin
         failures++; $display("FAIL hold_clear got=%h want=0", {busy, deadlock, dl_valid, dl_origin, dl_members, dl_count});
      end
      run(1, 19, p, fv, nb, fb);
      checks++; if (fv !== 19 || p !== 1 || dl_count !== 16'd1) begin
         failures++; $display("FAIL rereport got=%0d/%0d/%0d want=19/1/1", fv, p, dl_count);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      run(1, 18, p, fv, nb, fb);
      checks++; if (busy !== 1'b1 || p !== 0) begin failures++; $display("FAIL reach_check got=%b/%0d want=1/0", busy, p); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if ({dl_valid, deadlock, dl_count} !== 18'd0) begin
         failures++; $display("FAIL clear_in_check got=%h want=0", {dl_valid, deadlock, dl_count});
      end
      run(1, 5, p, fv, nb, fb);
      checks++; if (p !== 0 || dl_count !== 16'd0) begin failures++; $display("FAIL clear_in_check_after got=%0d/%0d want=0/0", p, dl_count); end
   endtask

   task automatic test_n8_saturate();
      int p, fv, nb, fb, tp, first;
      logic [63:0] m;
      tp = 0; first = -1;
      for (int r = 0; r < 4; r++) begin
         m = 64'd1 << 45;
         if (r % 2 == 1) m = m | (64'd1 << 55);
         wait8 = m;
         run(2, 25, p, fv, nb, fb);
         tp += p;
         if (r == 0) first = fv;
      end
      checks++; if (first !== 21) begin failures++; $display("FAIL n8_latency got=%0d want=21", first); end
      checks++; if (tp !== 4) begin failures++; $display("FAIL n8_pulses got=%0d want=4", tp); end
      checks++; if (count8 !== 2'd3) begin failures++; $display("FAIL n8_count_sat got=%0d want=3", count8); end
      checks++; if (origin8 !== 3'd5 || members8 !== 8'b0010_0000) begin
         failures++; $display("FAIL n8_report got=%0d/%b want=5/00100000", origin8, members8);
      end
   endtask

   task automatic test_async_reset();
      int p, fv, nb, fb;
      wait8 = 64'd1 << 45;
      run(2, 18, p, fv, nb, fb);
      checks++; if (busy8 !== 1'b1 || deadlock8 !== 1'b1) begin
         failures++; $display("FAIL n8_mid_close got=%b/%b want=1/1", busy8, deadlock8);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({busy8, deadlock8, dl_valid8, origin8, members8, count8} !== 16'd0) begin
         failures++; $display("FAIL async_reset got=%h want=0", {busy8, deadlock8, dl_valid8, origin8, members8, count8});
      end
      #2 reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_two_cycle();
      test_three_cycle();
      test_chain();
      test_toggle();
      test_abort();
      test_hold_clear();
      test_n8_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
endmodule
